pipeline_fetch_stage: RTL and testbench



---
 rtl/pipeline_fetch_stage.sv | 82 ++++++++
 tb/tb_pipeline_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register, branch/jump target
// generation, load-use hazard detection and saturating stall/flush counters.
module pipeline_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [31:0]      PCF,
  input  logic [31:0]      InstructionF,
  input  logic             BranchTakenD,
  input  logic             JumpD,
  input  logic             JumpRegD,
  input  logic [31:0]      JumpRegTargetD,
  input  logic             MemReadE,
  input  logic [4:0]       WriteRegE,
  output logic [31:0]      InstructionD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic             StallD,
  output logic             BubbleE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic        stall, redirect;
  logic [31:0] pc_plus4, branch_target, jump_target, jr_target, redirect_target;

  assign rs   = InstructionD[25:21];
  assign rt   = InstructionD[20:16];
  assign imm  = InstructionD[15:0];
  assign jidx = InstructionD[25:0];

  // Both source fields are compared for every opcode; a false stall is harmless.
  assign stall    = ValidD & MemReadE & (WriteRegE != 5'd0) &
                    ((WriteRegE == rs) | (WriteRegE == rt));
  assign redirect = ValidD & ~stall & (JumpRegD | JumpD | BranchTakenD);
  assign StallD   = stall;
  assign BubbleE  = stall;

  assign pc_plus4      = PCF + 32'd4;
  assign branch_target = PCPlus4D + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target   = {PCPlus4D[31:28], jidx, 2'b00};
  assign jr_target     = {JumpRegTargetD[31:2], 2'b00};

  always_comb begin
    redirect_target = branch_target;
    if (JumpRegD)   redirect_target = jr_target;
    else if (JumpD) redirect_target = jump_target;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCF          <= RESET_PC;
      InstructionD <= 32'd0;
      PCPlus4D     <= 32'd0;
      ValidD       <= 1'b0;
      StallCount   <= '0;
      FlushCount   <= '0;
    end else if (stall) begin
      // Redirect requests seen during a stall use stale operands and are dropped.
      if (StallCount != CNT_MAX) StallCount <= StallCount + 1'b1;
    end else if (redirect) begin
      PCF          <= redirect_target;
      InstructionD <= 32'd0;
      PCPlus4D     <= 32'd0;
      ValidD       <= 1'b0;
      if (FlushCount != CNT_MAX) FlushCount <= FlushCount + 1'b1;
    end else begin
      PCF          <= pc_plus4;
      InstructionD <= InstructionF;
      PCPlus4D     <= pc_plus4;
      ValidD       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Directed bench for pipeline_fetch_stage: sequencing, load-use stall,
// redirects, wrap-around, reset during stall and counter saturation.
module tb_pipeline_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] InstructionF, JumpRegTargetD;
  logic        BranchTakenD, JumpD, JumpRegD, MemReadE;
  logic [4:0]  WriteRegE;
  logic [31:0] PCF, InstructionD, PCPlus4D;
  logic        ValidD, StallD, BubbleE;
  logic [15:0] StallCount, FlushCount;
  logic [31:0] s_pcf, s_instr_d, s_pc4_d;
  logic        s_valid_d, s_stall_d, s_bubble_e;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int pass = 0;
  int total = 0;

  always #5 Clk = ~Clk;

  pipeline_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .PCF(PCF), .InstructionF(InstructionF),
    .BranchTakenD(BranchTakenD), .JumpD(JumpD), .JumpRegD(JumpRegD),
    .JumpRegTargetD(JumpRegTargetD), .MemReadE(MemReadE), .WriteRegE(WriteRegE),
    .InstructionD(InstructionD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .StallD(StallD), .BubbleE(BubbleE), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  pipeline_fetch_stage #(.RESET_PC(32'h0), .CNT_W(4)) sat (
    .Clk(Clk), .Reset(Reset), .PCF(s_pcf), .InstructionF(InstructionF),
    .BranchTakenD(BranchTakenD), .JumpD(JumpD), .JumpRegD(JumpRegD),
    .JumpRegTargetD(JumpRegTargetD), .MemReadE(MemReadE), .WriteRegE(WriteRegE),
    .InstructionD(s_instr_d), .PCPlus4D(s_pc4_d), .ValidD(s_valid_d),
    .StallD(s_stall_d), .BubbleE(s_bubble_e), .StallCount(s_stall_cnt), .FlushCount(s_flush_cnt)
  );

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] ADD = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] BEQ = 32'h1000_FFFF; // beq $0,$0,-1
  localparam logic [31:0] BEQ8 = 32'h1100_FFFE; // beq $8,$0,-2
  localparam logic [31:0] JMP = 32'h0800_0040; // j jidx=0x40

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic advance(input logic [31:0] instr);
    InstructionF = instr;
    step();
  endtask

  task automatic clear_ctl();
    BranchTakenD = 0; JumpD = 0; JumpRegD = 0; JumpRegTargetD = 0;
    MemReadE = 0; WriteRegE = 0;
  endtask

  task automatic do_reset();
    clear_ctl();
    InstructionF = NOP;
    Reset = 1;
    step();
    Reset = 0;
  endtask

  task automatic test_reset();
    Reset = 1; clear_ctl(); InstructionF = 32'hDEAD_BEEF;
    step(); step();
    total++; if (PCF !== 32'h0) $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); else pass++;
    total++; if (InstructionD !== 32'h0) $display("FAIL reset_instr got=%h exp=%h", InstructionD, 32'h0); else pass++;
    total++; if (PCPlus4D !== 32'h0) $display("FAIL reset_pc4 got=%h exp=%h", PCPlus4D, 32'h0); else pass++;
    total++; if (ValidD !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ValidD); else pass++;
    total++; if (StallCount !== 16'h0 || FlushCount !== 16'h0)
      $display("FAIL reset_counts got=%h/%h exp=0/0", StallCount, FlushCount); else pass++;
    Reset = 0;
  endtask

  task automatic test_normal();
    logic [31:0] exp_instr;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      advance(32'h2001_0004 + 32'(k));
      exp_instr = 32'h2001_0004 + 32'(k);
      total++; if (PCF !== 32'(4*k)) $display("FAIL normal_pcf[%0d] got=%h exp=%h", k, PCF, 32'(4*k)); else pass++;
      total++; if (InstructionD !== exp_instr) $display("FAIL normal_instr[%0d] got=%h exp=%h", k, InstructionD, exp_instr); else pass++;
      total++; if (PCPlus4D !== 32'(4*k)) $display("FAIL normal_pc4[%0d] got=%h exp=%h", k, PCPlus4D, 32'(4*k)); else pass++;
      total++; if (ValidD !== 1'b1) $display("FAIL normal_valid[%0d] got=%b exp=1", k, ValidD); else pass++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    advance(ADD); // D=add, PCF=4
    MemReadE = 1; WriteRegE = 5'd8; InstructionF = NOP; #1;
    total++; if (StallD !== 1'b1 || BubbleE !== 1'b1)
      $display("FAIL lu_stall_rs got=%b%b exp=11", StallD, BubbleE); else pass++;
    step();
    total++; if (PCF !== 32'h4) $display("FAIL lu_pcf_hold got=%h exp=%h", PCF, 32'h4); else pass++;
    total++; if (InstructionD !== ADD) $display("FAIL lu_instr_hold got=%h exp=%h", InstructionD, ADD); else pass++;
    total++; if (StallCount !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", StallCount); else pass++;
    MemReadE = 0; #1;
    total++; if (StallD !== 1'b0) $display("FAIL lu_release got=%b exp=0", StallD); else pass++;
    MemReadE = 1; WriteRegE = 5'd0; #1;
    total++; if (StallD !== 1'b0) $display("FAIL lu_r0 got=%b exp=0", StallD); else pass++;
    WriteRegE = 5'd9; #1;
    total++; if (StallD !== 1'b1) $display("FAIL lu_stall_rt got=%b exp=1", StallD); else pass++;
    WriteRegE = 5'd10; #1;
    total++; if (StallD !== 1'b0) $display("FAIL lu_rd_nomatch got=%b exp=0", StallD); else pass++;
    clear_ctl();
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) advance(NOP);
    advance(BEQ); // beq fetched at 0x10, PCPlus4D=0x14
    BranchTakenD = 1; InstructionF = 32'hBAD0_BAD0;
    step();
    total++; if (PCF !== 32'h10) $display("FAIL br_pcf got=%h exp=%h", PCF, 32'h10); else pass++;
    total++; if (ValidD !== 1'b0 || InstructionD !== 32'h0)
      $display("FAIL br_squash got=%b/%h exp=0/0", ValidD, InstructionD); else pass++;
    total++; if (FlushCount !== 16'd1) $display("FAIL br_flush_cnt got=%0d exp=1", FlushCount); else pass++;
    // BranchTakenD still high, but D holds a bubble: must fetch normally
    InstructionF = 32'h2001_0005;
    step();
    total++; if (PCF !== 32'h14 || ValidD !== 1'b1) $display("FAIL br_ignored_invalid got=%h/%b exp=14/1", PCF, ValidD); else pass++;
    total++; if (FlushCount !== 16'd1) $display("FAIL br_flush_hold got=%0d exp=1", FlushCount); else pass++;
    clear_ctl();
  endtask

  task automatic test_jump();
    do_reset();
    advance(NOP);
    JumpRegD = 1; JumpRegTargetD = 32'h8000_0002;
    step();
    total++; if (PCF !== 32'h8000_0000) $display("FAIL jr_pcf got=%h exp=%h", PCF, 32'h8000_0000); else pass++;
    clear_ctl();
    advance(JMP);
    total++; if (PCPlus4D !== 32'h8000_0004) $display("FAIL j_pc4 got=%h exp=%h", PCPlus4D, 32'h8000_0004); else pass++;
    JumpD = 1;
    step();
    total++; if (PCF !== 32'h8000_0100) $display("FAIL j_pcf got=%h exp=%h", PCF, 32'h8000_0100); else pass++;
    clear_ctl();
    advance(NOP);
    JumpRegD = 1; JumpD = 1; BranchTakenD = 1; JumpRegTargetD = 32'h0000_0123;
    step();
    total++; if (PCF !== 32'h0000_0120) $display("FAIL jr_prio got=%h exp=%h", PCF, 32'h0000_0120); else pass++;
    total++; if (FlushCount !== 16'd3) $display("FAIL j_flush_cnt got=%0d exp=3", FlushCount); else pass++;
    clear_ctl();
  endtask

  task automatic test_stall_vs_branch();
    // continues from test_jump: PCF=0x120, D empty, FlushCount=3
    advance(BEQ8); // D=beq $8, PCPlus4D=0x124
    MemReadE = 1; WriteRegE = 5'd8; BranchTakenD = 1;
    step();
    total++; if (PCF !== 32'h124 || ValidD !== 1'b1) $display("FAIL sb_held got=%h/%b exp=124/1", PCF, ValidD); else pass++;
    total++; if (FlushCount !== 16'd3 || StallCount !== 16'd1)
      $display("FAIL sb_counts got=%0d/%0d exp=3/1", FlushCount, StallCount); else pass++;
    MemReadE = 0;
    step();
    total++; if (PCF !== 32'h11C) $display("FAIL sb_redirect got=%h exp=%h", PCF, 32'h11C); else pass++;
    total++; if (FlushCount !== 16'd4) $display("FAIL sb_flush_cnt got=%0d exp=4", FlushCount); else pass++;
    clear_ctl();
  endtask

  task automatic test_wrap();
    advance(NOP);
    JumpRegD = 1; JumpRegTargetD = 32'hFFFF_FFFF;
    step();
    total++; if (PCF !== 32'hFFFF_FFFC) $display("FAIL wrap_setup got=%h exp=%h", PCF, 32'hFFFF_FFFC); else pass++;
    clear_ctl();
    advance(NOP);
    total++; if (PCF !== 32'h0 || PCPlus4D !== 32'h0)
      $display("FAIL wrap_pcf got=%h/%h exp=0/0", PCF, PCPlus4D); else pass++;
  endtask

  task automatic test_reset_mid_stall();
    advance(ADD);
    MemReadE = 1; WriteRegE = 5'd8; #1;
    total++; if (StallD !== 1'b1) $display("FAIL rs_pre_stall got=%b exp=1", StallD); else pass++;
    Reset = 1;
    step();
    total++; if (PCF !== 32'h0 || InstructionD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0)
      $display("FAIL rs_state got=%h/%h/%h/%b exp=0/0/0/0", PCF, InstructionD, PCPlus4D, ValidD); else pass++;
    total++; if (StallCount !== 16'd0 || FlushCount !== 16'd0 || StallD !== 1'b0)
      $display("FAIL rs_counts got=%0d/%0d/%b exp=0/0/0", StallCount, FlushCount, StallD); else pass++;
    Reset = 0; clear_ctl();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      advance(NOP);
      JumpRegD = 1; JumpRegTargetD = 32'h40;
      step();
      JumpRegD = 0;
    end
    total++; if (FlushCount !== 16'd17) $display("FAIL sat_flush16 got=%0d exp=17", FlushCount); else pass++;
    total++; if (s_flush_cnt !== 4'hF) $display("FAIL sat_flush4 got=%h exp=f", s_flush_cnt); else pass++;
    advance(ADD);
    MemReadE = 1; WriteRegE = 5'd9;
    repeat (65535) step();
    total++; if (StallCount !== 16'hFFFF) $display("FAIL sat_stall_reach got=%h exp=ffff", StallCount); else pass++;
    repeat (5) step();
    total++; if (StallCount !== 16'hFFFF) $display("FAIL sat_stall_hold got=%h exp=ffff", StallCount); else pass++;
    total++; if (s_stall_cnt !== 4'hF) $display("FAIL sat_stall4 got=%h exp=f", s_stall_cnt); else pass++;
    total++; if (PCF !== 32'h44 || InstructionD !== ADD)
      $display("FAIL sat_pc_held got=%h/%h exp=44/%h", PCF, InstructionD, ADD); else pass++;
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_branch();
    test_jump();
    test_stall_vs_branch();
    test_wrap();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
